morse_letter_decoder: RTL

- Downstream stage of the Morse letter transmitter.
- Receives the 1-bit Morse stream (dot = 1 unit high, dash = 3 units high, intra-letter gap = 1 unit low) and re-samples it at mid-unit.
- Assembles the received pattern, detects end-of-letter, and matches the pattern against the I..P table.
- Emits a 3-bit letter code (I=0 … P=7) with a valid pulse, or an error pulse; drives the board LEDR/HEX logic.

---
 rtl/morse_letter_decoder_pkg.sv | 63 ++++++
 rtl/morse_letter_decoder_tick_gen.sv | 38 +++
 rtl/morse_letter_decoder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/morse_letter_decoder_pkg.sv
// Shared Morse definitions for the I..P letter decoder: widths, letter codes,
// FSM states and the LSB-first pattern table also used by the transmitter.
package morse_pkg;

    localparam int unsigned PAT_W   = 13;
    localparam int unsigned END_GAP = 3;
    localparam int unsigned IDX_W   = $clog2(PAT_W + 1);
    localparam int unsigned ZR_W    = $clog2(END_GAP + 1);
    localparam int unsigned CODE_W  = 3;
    localparam int unsigned LEN_W   = 4;

    localparam logic [CODE_W-1:0] L_I = 3'd0;
    localparam logic [CODE_W-1:0] L_J = 3'd1;
    localparam logic [CODE_W-1:0] L_K = 3'd2;
    localparam logic [CODE_W-1:0] L_L = 3'd3;
    localparam logic [CODE_W-1:0] L_M = 3'd4;
    localparam logic [CODE_W-1:0] L_N = 3'd5;
    localparam logic [CODE_W-1:0] L_O = 3'd6;
    localparam logic [CODE_W-1:0] L_P = 3'd7;

    // First received unit sits in bit 0.
    localparam logic [PAT_W-1:0] PAT_I = 13'h0005;
    localparam logic [PAT_W-1:0] PAT_J = 13'h1DDD;
    localparam logic [PAT_W-1:0] PAT_K = 13'h01D7;
    localparam logic [PAT_W-1:0] PAT_L = 13'h015D;
    localparam logic [PAT_W-1:0] PAT_M = 13'h0077;
    localparam logic [PAT_W-1:0] PAT_N = 13'h0017;
    localparam logic [PAT_W-1:0] PAT_O = 13'h0777;
    localparam logic [PAT_W-1:0] PAT_P = 13'h05DD;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    typedef struct packed {
        logic              hit;
        logic [CODE_W-1:0] code;
    } match_t;

    // Look up a received pattern in the letter table.
    function automatic match_t match_pattern(input logic [PAT_W-1:0] pat);
        match_t m;
        m.hit  = 1'b1;
        m.code = L_I;
        case (pat)
            PAT_I:   m.code = L_I;
            PAT_J:   m.code = L_J;
            PAT_K:   m.code = L_K;
            PAT_L:   m.code = L_L;
            PAT_M:   m.code = L_M;
            PAT_N:   m.code = L_N;
            PAT_O:   m.code = L_O;
            PAT_P:   m.code = L_P;
            default: m.hit  = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/morse_letter_decoder_tick_gen.sv
// Unit-rate sample strobe: loadable down-counter. A half-period load centres
// the first sample in its unit; every zero reloads a full period.
module morse_tick_gen
#(
    parameter int unsigned TICK_DIV = 25000000
)
(
    input  logic clk,
    input  logic rst_n,
    input  logic load_half,
    input  logic run,
    output logic tick_c
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam int unsigned HALF  = TICK_DIV / 2 - 1;
    localparam int unsigned FULL  = TICK_DIV - 1;

    logic [DIV_W-1:0] cnt;

    // Count down while running; wrap reloads so the counter never underflows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load_half) begin
            cnt <= DIV_W'(HALF);
        end else if (run) begin
            if (cnt == '0) begin
                cnt <= DIV_W'(FULL);
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

    assign tick_c = run && (cnt == '0);

endmodule

// File: rtl/morse_letter_decoder.sv
// Morse letter decoder: re-samples the serial Morse stream at mid-unit,
// assembles an LSB-first pattern, detects the end-of-letter gap and matches
// against the I..P table. Optional macro MORSE_RAW_OUT_EN adds raw_pattern
// and raw_len debug outputs.
module morse_letter_decoder
    import morse_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25000000
)
(
    input  logic                CLOCK_50,
    input  logic                KEY,
    input  logic                serial_in,
    output logic [CODE_W-1:0]   letter,
    output logic                letter_valid,
    output logic                err,
    output logic                busy
`ifdef MORSE_RAW_OUT_EN
    ,
    output logic [PAT_W-1:0]    raw_pattern,
    output logic [LEN_W-1:0]    raw_len
`endif
);

    state_t             state, state_nxt;
    logic               s_q;
    logic [PAT_W-1:0]   pattern, pattern_nxt;
    logic [IDX_W-1:0]   bit_idx, bit_idx_nxt;
    logic [ZR_W-1:0]    zero_run, zero_run_nxt;
    logic [CODE_W-1:0]  letter_nxt;
    logic               letter_valid_nxt;
    logic               err_nxt;
    logic               load_half_c;
    logic               run_c;
    logic               tick_c;
    match_t             match_c;
`ifdef MORSE_RAW_OUT_EN
    logic [PAT_W-1:0]   raw_pattern_nxt;
    logic [LEN_W-1:0]   raw_len_nxt;
`endif

    // Mid-unit sample strobe.
    morse_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk       (CLOCK_50),
        .rst_n     (KEY),
        .load_half (load_half_c),
        .run       (run_c),
        .tick_c    (tick_c)
    );

    // State, datapath and registered outputs.
    always_ff @(posedge CLOCK_50) begin
        if (!KEY) begin
            state        <= IDLE;
            s_q          <= 1'b0;
            pattern      <= '0;
            bit_idx      <= '0;
            zero_run     <= '0;
            letter       <= '0;
            letter_valid <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
`ifdef MORSE_RAW_OUT_EN
            raw_pattern  <= '0;
            raw_len      <= '0;
`endif
        end else begin
            state        <= state_nxt;
            s_q          <= serial_in;
            pattern      <= pattern_nxt;
            bit_idx      <= bit_idx_nxt;
            zero_run     <= zero_run_nxt;
            letter       <= letter_nxt;
            letter_valid <= letter_valid_nxt;
            err          <= err_nxt;
            busy         <= (state_nxt != IDLE);
`ifdef MORSE_RAW_OUT_EN
            raw_pattern  <= raw_pattern_nxt;
            raw_len      <= raw_len_nxt;
`endif
        end
    end

    // Next-state, sample assembly and end-of-letter decode.
    // The terminating zero sample never alters the pattern, so the table
    // lookup on the current pattern is final and the result is registered
    // on that same edge (visible during the DONE cycle).
    always_comb begin
        state_nxt        = state;
        pattern_nxt      = pattern;
        bit_idx_nxt      = bit_idx;
        zero_run_nxt     = zero_run;
        letter_nxt       = letter;
        letter_valid_nxt = 1'b0;
        err_nxt          = 1'b0;
        load_half_c      = 1'b0;
        run_c            = 1'b0;
        match_c          = match_pattern(pattern);
`ifdef MORSE_RAW_OUT_EN
        raw_pattern_nxt  = raw_pattern;
        raw_len_nxt      = raw_len;
`endif

        case (state)
            IDLE: begin
                if (s_q) begin
                    state_nxt    = ALIGN;
                    load_half_c  = 1'b1;
                    pattern_nxt  = '0;
                    bit_idx_nxt  = '0;
                    zero_run_nxt = '0;
                end
            end

            ALIGN, RUN, FLUSH: begin
                run_c = 1'b1;
                if (tick_c) begin
                    if (bit_idx < IDX_W'(PAT_W)) begin
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end
                    if (s_q) begin
                        zero_run_nxt = '0;
                        if (bit_idx < IDX_W'(PAT_W)) begin
                            pattern_nxt = pattern | (PAT_W'(1) << bit_idx);
                            state_nxt   = (state == FLUSH) ? FLUSH : RUN;
                        end else begin
                            state_nxt   = FLUSH;
                        end
                    end else begin
                        zero_run_nxt = zero_run + ZR_W'(1);
                        if (state == ALIGN) begin
                            state_nxt = RUN;
                        end
                        if (zero_run_nxt == ZR_W'(END_GAP)) begin
                            if (state == FLUSH) begin
                                err_nxt   = 1'b1;
                                state_nxt = IDLE;
                            end else begin
                                state_nxt = DONE;
                                if (match_c.hit) begin
                                    letter_nxt       = match_c.code;
                                    letter_valid_nxt = 1'b1;
                                end else begin
                                    err_nxt          = 1'b1;
                                end
                            end
`ifdef MORSE_RAW_OUT_EN
                            raw_pattern_nxt = pattern;
                            raw_len_nxt     = LEN_W'(bit_idx_nxt - IDX_W'(END_GAP));
`endif
                        end
                    end
                end
            end

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
